lcd_fill_sequencer: RTL and testbench

- Hardware fill engine that sits upstream of the ST7789 9-bit word serializer (bit 8 = DC: 0 command, 1 parameter/data; bits 7:0 = SPI byte).
- Given a rectangle and an RGB565 colour, it emits the full command stream: CASET, RASET, RAMWR, then the pixel data. The CPU no longer has to push every pixel byte through CSRs.
- It also arbitrates the serializer between this engine and the CPU CSR word path.

---
 rtl/lcd_fill_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_lcd_fill_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fill_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_fill_sequencer
// Purpose  : ST7789 rectangle fill engine (CASET/RASET/RAMWR + pixel stream)
//            with CPU pass-through arbitration onto the 9-bit serializer path.
// Revision : 1.0  initial release
// ============================================================================
module lcd_fill_sequencer #(
  parameter int X_OFFSET = 40,
  parameter int Y_OFFSET = 53,
  parameter int WIDTH    = 240,
  parameter int HEIGHT   = 135
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  x0,
  input  logic [8:0]  x1,
  input  logic [8:0]  y0,
  input  logic [8:0]  y1,
  input  logic [15:0] color,
  input  logic        abort,
  input  logic        cpu_valid,
  input  logic [8:0]  cpu_data,
  output logic        cpu_ready,
  output logic        out_valid,
  output logic [8:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [15:0] c_x_off  = 16'(X_OFFSET);
  localparam logic [15:0] c_y_off  = 16'(Y_OFFSET);
  localparam logic [8:0]  c_width  = 9'(WIDTH);
  localparam logic [8:0]  c_height = 9'(HEIGHT);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CASET_C  = 4'd1,
    S_CASET_P0 = 4'd2,
    S_CASET_P1 = 4'd3,
    S_CASET_P2 = 4'd4,
    S_CASET_P3 = 4'd5,
    S_RASET_C  = 4'd6,
    S_RASET_P0 = 4'd7,
    S_RASET_P1 = 4'd8,
    S_RASET_P2 = 4'd9,
    S_RASET_P3 = 4'd10,
    S_RAMWR    = 4'd11,
    S_PIX_HI   = 4'd12,
    S_PIX_LO   = 4'd13,
    S_DONE     = 4'd14
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  state_t      w_adv;

  logic [15:0] r_cx0;
  logic [15:0] r_cx1;
  logic [15:0] r_ry0;
  logic [15:0] r_ry1;
  logic [15:0] r_color;
  logic [15:0] r_cnt;
  logic        r_abort_pend;
  logic        r_err;

  logic        w_bad;
  logic        w_accept;
  logic        w_xfer;
  logic        w_abort_eff;
  logic [8:0]  w_xspan;
  logic [8:0]  w_yspan;
  logic [15:0] w_npix;

  assign w_bad = (x1 < x0) || (y1 < y0) || (x1 >= c_width) || (y1 >= c_height);
  assign w_xspan = x1 - x0 + 9'd1;
  assign w_yspan = y1 - y0 + 9'd1;
  assign w_npix  = 16'(w_xspan) * 16'(w_yspan);

  assign w_accept    = cmd_valid & cmd_ready;
  assign w_xfer      = out_valid & out_ready;
  assign w_abort_eff = abort | r_abort_pend;

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign err  = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = r_state;
    out_valid   = 1'b0;
    out_data    = 9'h000;
    cmd_ready   = 1'b0;
    cpu_ready   = 1'b0;

    case (r_state)
      S_IDLE: begin
        // CPU words win; a fill request waits until no CPU word is pending.
        out_valid = cpu_valid & ~rst;
        out_data  = (cpu_valid && !rst) ? cpu_data : 9'h000;
        cpu_ready = out_ready & ~rst;
        cmd_ready = ~cpu_valid & ~rst;
        if (cmd_valid && !cpu_valid && !rst && !w_bad) begin
          w_state_nxt = S_CASET_C;
        end
      end
      S_CASET_C:  begin out_valid = 1'b1; out_data = 9'h02A;                 w_adv = S_CASET_P0; end
      S_CASET_P0: begin out_valid = 1'b1; out_data = {1'b1, r_cx0[15:8]};    w_adv = S_CASET_P1; end
      S_CASET_P1: begin out_valid = 1'b1; out_data = {1'b1, r_cx0[7:0]};     w_adv = S_CASET_P2; end
      S_CASET_P2: begin out_valid = 1'b1; out_data = {1'b1, r_cx1[15:8]};    w_adv = S_CASET_P3; end
      S_CASET_P3: begin out_valid = 1'b1; out_data = {1'b1, r_cx1[7:0]};     w_adv = S_RASET_C;  end
      S_RASET_C:  begin out_valid = 1'b1; out_data = 9'h02B;                 w_adv = S_RASET_P0; end
      S_RASET_P0: begin out_valid = 1'b1; out_data = {1'b1, r_ry0[15:8]};    w_adv = S_RASET_P1; end
      S_RASET_P1: begin out_valid = 1'b1; out_data = {1'b1, r_ry0[7:0]};     w_adv = S_RASET_P2; end
      S_RASET_P2: begin out_valid = 1'b1; out_data = {1'b1, r_ry1[15:8]};    w_adv = S_RASET_P3; end
      S_RASET_P3: begin out_valid = 1'b1; out_data = {1'b1, r_ry1[7:0]};     w_adv = S_RAMWR;    end
      S_RAMWR:    begin out_valid = 1'b1; out_data = 9'h02C;                 w_adv = S_PIX_HI;   end
      S_PIX_HI:   begin out_valid = 1'b1; out_data = {1'b1, r_color[15:8]};  w_adv = S_PIX_LO;   end
      S_PIX_LO:   begin out_valid = 1'b1; out_data = {1'b1, r_color[7:0]};   w_adv = S_PIX_HI;   end
      S_DONE:     begin w_state_nxt = S_IDLE; end
      default:    begin w_state_nxt = S_IDLE; end
    endcase

    // The final pixel transfer completes normally even if abort coincides.
    if (r_state != S_IDLE && out_valid && out_ready) begin
      if (r_state == S_PIX_LO && r_cnt == 16'd1) begin
        w_state_nxt = S_DONE;
      end else if (w_abort_eff) begin
        w_state_nxt = S_IDLE;
      end else begin
        w_state_nxt = w_adv;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx0        <= 16'd0;
      r_cx1        <= 16'd0;
      r_ry0        <= 16'd0;
      r_ry1        <= 16'd0;
      r_color      <= 16'd0;
      r_cnt        <= 16'd0;
      r_abort_pend <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= w_accept & w_bad;

      if (w_accept && !w_bad) begin
        r_cx0   <= {7'd0, x0} + c_x_off;
        r_cx1   <= {7'd0, x1} + c_x_off;
        r_ry0   <= {7'd0, y0} + c_y_off;
        r_ry1   <= {7'd0, y1} + c_y_off;
        r_color <= color;
        r_cnt   <= w_npix;
      end else if (r_state == S_PIX_LO && w_xfer) begin
        r_cnt <= r_cnt - 16'd1;
      end

      if (w_state_nxt == S_IDLE) begin
        r_abort_pend <= 1'b0;
      end else if (abort && r_state != S_IDLE) begin
        r_abort_pend <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lcd_fill_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_fill_sequencer
// Purpose  : Scoreboard bench for lcd_fill_sequencer with directed fills.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_fill_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [8:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [15:0] color = '0;
  logic        abort = 1'b0;
  logic        cpu_valid = 1'b0;
  logic [8:0]  cpu_data = '0;
  logic        out_ready = 1'b0;
  logic        cmd_ready, cpu_ready, out_valid, busy, done, err;
  logic [8:0]  out_data;

  int          total = 0;
  int          bad = 0;
  logic [8:0]  sb[$];

  always #5 clk = ~clk;

  lcd_fill_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color), .abort(abort),
    .cpu_valid(cpu_valid), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks stall stability.
  logic [8:0] held;
  bit         was_stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled) begin
        check("stall_hold_valid", {31'd0, out_valid}, 32'd1);
        check("stall_hold_data", {23'd0, out_data}, {23'd0, held});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", out_data);
        end else begin
          check("word", {23'd0, out_data}, {23'd0, sb.pop_front()});
        end
      end
      was_stalled = out_valid && !out_ready;
      held = out_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_list(input logic [8:0] w[13]);
    for (int i = 0; i < 13; i++) sb.push_back(w[i]);
  endtask

  // Presents a request and returns one step after the accepting edge (T+1).
  task automatic issue(input logic [8:0] a, input logic [8:0] b, input logic [8:0] c,
                       input logic [8:0] d, input logic [15:0] col);
    int g;
    g = 0;
    x0 = a; x1 = b; y0 = c; y1 = d; color = col; cmd_valid = 1'b1;
    #1;
    while (!cmd_ready && g < 50) begin
      step();
      #1;
      g++;
    end
    check("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output int cyc, output int nv);
    cyc = 1;
    nv = 0;
    while (!done && cyc < budget) begin
      if (out_valid) nv++;
      if (rnd) out_ready = ($urandom_range(0, 9) < 7);
      step();
      cyc++;
    end
    out_ready = 1'b1;
    check("done_seen", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int         cyc, nv;
    logic [8:0] w1x1[13];
    logic [8:0] wab[13];
    logic [8:0] hdr[13];
    w1x1 = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h128, 9'h02B, 9'h100, 9'h135,
             9'h100, 9'h135, 9'h02C, 9'h1F8, 9'h100};
    wab  = '{9'h02A, 9'h100, 9'h128, 9'h100, 9'h129, 9'h02B, 9'h100, 9'h135,
             9'h100, 9'h135, 9'h02C, 9'h112, 9'h134};
    hdr  = '{9'h02A, 9'h100, 9'h128, 9'h101, 9'h117, 9'h02B, 9'h100, 9'h199,
             9'h100, 9'h1BB, 9'h02C, 9'h000, 9'h000};

    // Reset state
    out_ready = 1'b1;
    repeat (2) step();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {23'd0, out_data}, 32'd0);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    step();
    check("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // 1x1 fill at full throughput
    push_list(w1x1);
    issue(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
    wait_done(100, 1'b0, cyc, nv);
    check("1x1_done_cycle", cyc, 32'd14);
    check("1x1_valid_cycles", nv, 32'd13);
    step();
    check("1x1_busy_after", {31'd0, busy}, 32'd0);
    check("1x1_sb_empty", sb.size(), 32'd0);

    // Rejected requests
    issue(9'd10, 9'd5, 9'd0, 9'd0, 16'h1111);
    check("err_x_pulse", {31'd0, err}, 32'd1);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || busy) nv++;
      step();
    end
    check("err_x_quiet", nv, 32'd0);
    check("err_x_pulse_end", {31'd0, err}, 32'd0);
    issue(9'd0, 9'd5, 9'd0, 9'd135, 16'h2222);
    check("err_y_pulse", {31'd0, err}, 32'd1);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid || busy) nv++;
      step();
    end
    check("err_y_quiet", nv, 32'd0);

    // CPU word and fill request together
    sb.push_back(9'h029);
    push_list(w1x1);
    x0 = 9'd0; x1 = 9'd0; y0 = 9'd0; y1 = 9'd0; color = 16'hF800;
    cpu_valid = 1'b1; cpu_data = 9'h029; cmd_valid = 1'b1;
    #1;
    check("arb_cmd_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("arb_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    step();
    cpu_valid = 1'b0;
    #1;
    check("arb_cmd_ready_high", {31'd0, cmd_ready}, 32'd1);
    step();
    cmd_valid = 1'b0;
    check("arb_hdr_first", {23'd0, out_data}, 32'h02A);
    wait_done(100, 1'b0, cyc, nv);
    check("arb_done_cycle", cyc, 32'd14);
    step();
    check("arb_sb_empty", sb.size(), 32'd0);

    // Abort while the PIX_LO word is stalled
    push_list(wab);
    issue(9'd0, 9'd1, 9'd0, 9'd0, 16'h1234);
    repeat (12) step();
    check("abort_pixlo_present", {23'd0, out_data}, 32'h134);
    out_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    repeat (2) step();
    check("abort_still_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1;
    step();
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, done}, 32'd0);
    sb.push_back(9'h1AB);
    cpu_valid = 1'b1; cpu_data = 9'h1AB;
    #1;
    check("abort_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    step();
    cpu_valid = 1'b0;
    check("abort_no_done2", {30'd0, done, err}, 32'd0);
    check("abort_sb_empty", sb.size(), 32'd0);

    // Reset in RASET_P2, then a clean fill
    for (int i = 0; i < 8; i++) sb.push_back(w1x1[i]);
    issue(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
    repeat (8) step();
    check("rst_mid_word", {23'd0, out_data}, 32'h100);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    step();
    check("rst_mid_sb", sb.size(), 32'd0);
    push_list(w1x1);
    issue(9'd0, 9'd0, 9'd0, 9'd0, 16'hF800);
    wait_done(100, 1'b0, cyc, nv);
    check("rst_refill_cycle", cyc, 32'd14);
    step();
    check("rst_refill_sb", sb.size(), 32'd0);

    // Boundary rectangle, random back-pressure
    for (int i = 0; i < 11; i++) sb.push_back(hdr[i]);
    for (int i = 0; i < 8400; i++) begin
      sb.push_back(9'h107);
      sb.push_back(9'h1E0);
    end
    issue(9'd0, 9'd239, 9'd100, 9'd134, 16'h07E0);
    wait_done(40000, 1'b1, cyc, nv);
    step();
    check("big_busy_after", {31'd0, busy}, 32'd0);
    check("big_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
